pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle core. It holds the fetch address and evaluates the 3-bit branch condition against the Z/V/N flags. It supports PC-relative branches (B) and register-indirect branches (BR), and adds pipeline stall and a sticky HALT state. It replaces the fixed 16-bit PC/branch pair at the front of fetch and drives the instruction-memory address and the PC+2 value used by PCS.

## Interface
- WIDTH, 16, PC and target width in bits
- IMM_W, 9, branch immediate width in bits (word offset, signed)
- INC, 2, sequential increment in bytes
- RESET_ADDR, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC; ignore branch and hlt this cycle
- br_valid  in  1  current instruction is a branch
- br_reg  in  1  0 = B (PC-relative), 1 = BR (register target); valid with br_valid
- cond  in  3  branch condition code
- imm  in  IMM_W  signed word offset for B
- reg_target  in  WIDTH  target address for BR
- flags  in  3  {Z, V, N} from the flag register
- hlt  in  1  current instruction is HLT
- pc  out  WIDTH  current fetch address
- pc_seq  out  WIDTH  pc + INC (combinational, modulo 2^WIDTH)
- taken  out  1  combinational: branch taken this cycle
- halted  out  1  registered: unit is in HALT state

## Operation
- States: RUN, HALT. Reset puts the unit in RUN with pc = RESET_ADDR.
- Condition truth, using flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 UNCOND: always true
- taken = br_valid & cond_true & ~stall & state==RUN & ~hlt.
- B target = pc_seq + (sign_extend(imm) << 1), truncated to WIDTH.
- BR target = reg_target; bit 0 is forced to 0.
- Next-PC priority:
  - rst: pc = RESET_ADDR
  - HALT: hold pc
  - stall: hold pc
  - hlt: hold pc, enter HALT
  - taken: pc = target
  - otherwise: pc = pc_seq
- HALT is sticky. Only rst leaves it. All inputs are ignored while halted.
- hlt together with br_valid: hlt wins and taken = 0.
- All arithmetic wraps modulo 2^WIDTH; no overflow is flagged.

## Timing
- Reset values: pc = RESET_ADDR, halted = 0. pc_seq = RESET_ADDR + INC. taken = 0 unless inputs assert it combinationally.
- pc updates one cycle after the inputs are sampled. taken and pc_seq are same-cycle combinational.
- halted rises in the cycle after hlt is sampled. pc keeps the HLT instruction's address.
- stall has zero latency. A stalled branch is re-evaluated when stall drops; the driving stage must hold the inputs.
- rst asserted while in HALT or during a stall: the next edge gives pc = RESET_ADDR and halted = 0.

## Configuration
- PC_TRACE_EN defined: adds these outputs, all reset to 0 by rst:
  - retired (32-bit): increments once per non-stalled RUN cycle, including the HLT cycle.
  - last_br_src (WIDTH): the pc of the most recent taken branch.
  - last_br_dst (WIDTH): that branch's target.
- PC_TRACE_EN undefined: these ports and registers are absent. Core behaviour is identical.

## Test plan
- Reset and sequential run: rst for 2 cycles, then 3 idle cycles -> pc = 0x0000, 0x0002, 0x0004, 0x0006; halted = 0.
- Backward B: at pc = 0x0010, B with cond = 001, flags Z=1, imm = 9'h1FC (-4) -> taken = 1, next pc = 0x0012 - 8 = 0x000A. Same stimulus with Z=0 -> next pc = 0x0012.
- BR and wrap: at pc = 0xFFFE with no branch -> next pc = 0x0000. Then BR with cond = 111, reg_target = 0x1235 -> next pc = 0x1234.
- Stall: at pc = 0x0020, stall = 1 for 3 cycles with an asserted taken-condition B (imm = 4) -> pc holds 0x0020 and taken = 0. After stall drops -> pc = 0x002A.
- HALT: at pc = 0x0040, hlt = 1 together with br_valid = 1 -> pc stays 0x0040, halted = 1 next cycle. Further branches are ignored. rst -> pc = 0x0000, halted = 0.
- PC_TRACE_EN: after the backward-B scenario -> last_br_src = 0x0010, last_br_dst = 0x000A, and retired equals the non-stalled cycle count.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with B/BR branch evaluation, stall, and a sticky HALT state.
// Define PC_TRACE_EN to add the retired/last_br_src/last_br_dst trace outputs.
module pc_unit #(
  parameter int              WIDTH      = 16,
  parameter int              IMM_W      = 9,
  parameter int              INC        = 2,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [2:0]       flags,
  input  logic             hlt,
`ifdef PC_TRACE_EN
  output logic [31:0]      retired,
  output logic [WIDTH-1:0] last_br_src,
  output logic [WIDTH-1:0] last_br_dst,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             taken,
  output logic             halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             cond_true;
  logic             flag_z, flag_v, flag_n;
  logic [WIDTH-1:0] imm_ext, b_target, target;
  logic             active;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000: cond_true = ~flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = ~flag_z & ~flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z | ~flag_n;
      3'b101: cond_true = flag_n | flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Sign-extend the word offset, then scale to bytes.
  assign imm_ext  = WIDTH'(signed'(imm));
  assign pc_seq   = pc_q + WIDTH'(INC);
  assign b_target = pc_seq + (imm_ext << 1);
  assign target   = br_reg ? {reg_target[WIDTH-1:1], 1'b0} : b_target;

  assign active = (state_q == RUN) & ~stall;
  assign taken  = br_valid & cond_true & active & ~hlt;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (active) begin
      if (hlt) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else if (taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign halted = halted_q;

`ifdef PC_TRACE_EN
  logic [31:0]      retired_q, retired_d;
  logic [WIDTH-1:0] last_br_src_q, last_br_src_d;
  logic [WIDTH-1:0] last_br_dst_q, last_br_dst_d;

  always_comb begin
    retired_d     = retired_q;
    last_br_src_d = last_br_src_q;
    last_br_dst_d = last_br_dst_q;
    if (active) retired_d = retired_q + 32'd1;
    if (taken) begin
      last_br_src_d = pc_q;
      last_br_dst_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q     <= '0;
      last_br_src_q <= '0;
      last_br_dst_q <= '0;
    end else begin
      retired_q     <= retired_d;
      last_br_src_q <= last_br_src_d;
      last_br_dst_q <= last_br_dst_d;
    end
  end

  assign retired     = retired_q;
  assign last_br_src = last_br_src_q;
  assign last_br_dst = last_br_dst_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: reset, B/BR, conditions, wrap, stall, HALT.
module tb_pc_unit;
  localparam int WIDTH = 16;
  localparam int IMM_W = 9;

  logic             clk = 1'b0;
  logic             rst, stall, br_valid, br_reg, hlt;
  logic [2:0]       cond, flags;
  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] pc, pc_seq;
  logic             taken, halted;
`ifdef PC_TRACE_EN
  logic [31:0]      retired;
  logic [WIDTH-1:0] last_br_src, last_br_dst;
`endif

  int checks = 0;
  int passes = 0;

  pc_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W), .INC(2), .RESET_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_reg(br_reg),
    .cond(cond), .imm(imm), .reg_target(reg_target), .flags(flags), .hlt(hlt),
`ifdef PC_TRACE_EN
    .retired(retired), .last_br_src(last_br_src), .last_br_dst(last_br_dst),
`endif
    .pc(pc), .pc_seq(pc_seq), .taken(taken), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; br_valid = 0; br_reg = 0; cond = 0; imm = 0;
    reg_target = 0; flags = 0; hlt = 0;
  endtask

  // Unconditional BR to reach a chosen pc.
  task automatic jump(input logic [WIDTH-1:0] a);
    idle();
    br_valid = 1; br_reg = 1; cond = 3'b111; reg_target = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step(); step();
    checks++; if (pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", pc); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else passes++;
    checks++; if (pc_seq !== 16'h0002) $display("FAIL reset_pc_seq got %h want 0002", pc_seq); else passes++;
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc !== 16'(2 * i)) $display("FAIL seq_pc%0d got %h want %h", i, pc, 16'(2 * i)); else passes++;
    end
    checks++; if (halted !== 1'b0) $display("FAIL seq_halted got %b want 0", halted); else passes++;
`ifdef PC_TRACE_EN
    checks++; if (retired !== 32'd3) $display("FAIL retired_seq got %0d want 3", retired); else passes++;
`endif
  endtask

  task automatic test_branch_b();
    jump(16'h0010);
    br_valid = 1; br_reg = 0; cond = 3'b001; flags = 3'b100; imm = 9'h1FC;
    #1;
    checks++; if (taken !== 1'b1) $display("FAIL b_taken got %b want 1", taken); else passes++;
    step(); idle();
    checks++; if (pc !== 16'h000A) $display("FAIL b_back_pc got %h want 000A", pc); else passes++;
`ifdef PC_TRACE_EN
    checks++; if (last_br_src !== 16'h0010) $display("FAIL last_br_src got %h want 0010", last_br_src); else passes++;
    checks++; if (last_br_dst !== 16'h000A) $display("FAIL last_br_dst got %h want 000A", last_br_dst); else passes++;
`endif
    jump(16'h0010);
    br_valid = 1; br_reg = 0; cond = 3'b001; flags = 3'b000; imm = 9'h1FC;
    #1;
    checks++; if (taken !== 1'b0) $display("FAIL b_not_taken got %b want 0", taken); else passes++;
    step(); idle();
    checks++; if (pc !== 16'h0012) $display("FAIL b_fallthru_pc got %h want 0012", pc); else passes++;
  endtask

  task automatic test_conds();
    logic [2:0] fl [3];
    logic [7:0] ex [3];
    // ex[k][c] is the expected truth of condition c under fl[k] = {Z,V,N}.
    fl[0] = 3'b000; ex[0] = 8'b1001_0101;
    fl[1] = 3'b101; ex[1] = 8'b1011_1010;
    fl[2] = 3'b011; ex[2] = 8'b1110_1001;
    idle();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 8; c++) begin
        br_valid = 1; cond = 3'(c); flags = fl[k];
        #1;
        checks++;
        if (taken !== ex[k][c])
          $display("FAIL cond%0d_flags%b got %b want %b", c, fl[k], taken, ex[k][c]);
        else passes++;
      end
    end
    idle();
  endtask

  task automatic test_wrap_br();
    jump(16'hFFFE);
    checks++; if (pc_seq !== 16'h0000) $display("FAIL wrap_pc_seq got %h want 0000", pc_seq); else passes++;
    step();
    checks++; if (pc !== 16'h0000) $display("FAIL wrap_pc got %h want 0000", pc); else passes++;
    br_valid = 1; br_reg = 1; cond = 3'b111; reg_target = 16'h1235;
    step(); idle();
    checks++; if (pc !== 16'h1234) $display("FAIL br_pc got %h want 1234", pc); else passes++;
  endtask

  task automatic test_stall();
    jump(16'h0020);
    br_valid = 1; br_reg = 0; cond = 3'b111; imm = 9'd4; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (taken !== 1'b0) $display("FAIL stall_taken%0d got %b want 0", i, taken); else passes++;
      step();
      checks++; if (pc !== 16'h0020) $display("FAIL stall_pc%0d got %h want 0020", i, pc); else passes++;
    end
    stall = 0;
    #1;
    checks++; if (taken !== 1'b1) $display("FAIL unstall_taken got %b want 1", taken); else passes++;
    step(); idle();
    checks++; if (pc !== 16'h002A) $display("FAIL unstall_pc got %h want 002A", pc); else passes++;
  endtask

  task automatic test_halt();
    jump(16'h0040);
    hlt = 1; br_valid = 1; br_reg = 1; cond = 3'b111; reg_target = 16'h0100;
    #1;
    checks++; if (taken !== 1'b0) $display("FAIL hlt_br_taken got %b want 0", taken); else passes++;
    step();
    hlt = 0;
    #1;
    checks++; if (halted !== 1'b1) $display("FAIL halted got %b want 1", halted); else passes++;
    checks++; if (pc !== 16'h0040) $display("FAIL halt_pc got %h want 0040", pc); else passes++;
    checks++; if (taken !== 1'b0) $display("FAIL halted_taken got %b want 0", taken); else passes++;
    step(); step();
    checks++; if (pc !== 16'h0040) $display("FAIL halt_hold_pc got %h want 0040", pc); else passes++;
    checks++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b want 1", halted); else passes++;
    idle();
    rst = 1; stall = 1;
    step();
    rst = 0; stall = 0;
    checks++; if (pc !== 16'h0000) $display("FAIL halt_rst_pc got %h want 0000", pc); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL halt_rst_halted got %b want 0", halted); else passes++;
`ifdef PC_TRACE_EN
    checks++; if (retired !== 32'd0) $display("FAIL retired_rst got %0d want 0", retired); else passes++;
`endif
    step();
    checks++; if (pc !== 16'h0002) $display("FAIL post_rst_pc got %h want 0002", pc); else passes++;
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_branch_b();
    test_conds();
    test_wrap_br();
    test_stall();
    test_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
